// File: rtl/fwd_pkg.sv
// Shared types and constants for the EX-stage forwarding / hazard controller.
package fwd_pkg;

    // Widest register address a shadow-pipeline entry can hold; REG_AW must not exceed it.
    localparam int STAGE_AW = 8;

    // Operand select value meaning "take the operand from the register file".
    localparam int FWD_NONE = 0;

    // One in-flight instruction as seen by the forwarding logic.
    typedef struct packed {
        logic                valid;
        logic                wr;
        logic                is_load;
        logic [STAGE_AW-1:0] dst;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '0;

    // Bits needed to encode selects 0..depth (0 = regfile, k = k-th stage after EX).
    function automatic int sel_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lat_scoreboard.sv
// Per-register countdown scoreboard for long-latency ops. A counter is loaded
// with the op latency at issue and counts down to zero, at which point the
// result is in the register file. Register 0 never holds a pending result.
module lat_scoreboard
    import fwd_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int LAT_W  = 3,
    parameter int NQ     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_addr,
    input  logic [LAT_W-1:0]  set_val,
    input  logic [NQ*REG_AW-1:0] q_addr,
    output logic [NQ-1:0]     q_busy,
    output logic              any_busy
);

    localparam int NREG = 1 << REG_AW;

    // One "counter is nonzero" flag per register; queries and the global busy flag read these.
    logic [NREG-1:0] nz;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_cell
            if (gi == 0) begin : g_zero
                assign nz[gi] = 1'b0;
            end else begin : g_cnt
                logic [LAT_W-1:0] cnt_reg;

                // Load on issue, otherwise count down towards zero.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        cnt_reg <= '0;
                    end else if (set_en && (set_addr == REG_AW'(gi))) begin
                        cnt_reg <= set_val;
                    end else if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - LAT_W'(1);
                    end
                end

                assign nz[gi] = (cnt_reg != '0);
            end
        end

        for (gi = 0; gi < NQ; gi++) begin : g_query
            assign q_busy[gi] = nz[q_addr[gi*REG_AW +: REG_AW]];
        end
    endgenerate

    assign any_busy = |nz;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding and ID hazard controller. A shadow pipeline mirrors the
// destination registers of in-flight pipelined instructions so that the EX
// operand selects can be computed in ID and registered alongside the
// instruction. Load-use and long-latency hazards stall ID.
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_AW    = 4,
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int LAT_W     = 3,
    parameter int CNT_W     = 16,
    localparam int SEL_W    = sel_width(FWD_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic                      id_wr,
    input  logic [REG_AW-1:0]         id_dst,
    input  logic                      id_is_load,
    input  logic [LAT_W-1:0]          id_lat,
    output logic                      stall,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      ex_valid,
    output logic                      lat_busy,
    output logic [CNT_W-1:0]          stall_cycles
);

    localparam int NQ = NUM_SRC + 1;

    // shadow_reg[0] is the instruction in EX, shadow_reg[k] is k stages past EX.
    stage_t [FWD_DEPTH:0]      shadow_reg;
    stage_t                    s0_next;

    logic                      issue;
    logic                      long_op;
    logic                      load_use;
    logic                      wr_hazard;
    logic                      sb_hazard;
    logic                      sb_set;
    logic                      stall_int;
    logic [NUM_SRC-1:0]        src_live;
    logic [NUM_SRC-1:0]        lu_hit;
    logic [NUM_SRC-1:0]        sb_src_hit;
    logic [NUM_SRC*SEL_W-1:0]  sel_next;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel_reg;
    logic [NQ*REG_AW-1:0]      q_addr;
    logic [NQ-1:0]             q_busy;
    logic [CNT_W-1:0]          stall_cnt_reg;

    assign long_op = (id_lat != '0);

    genvar gi, gk;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [REG_AW-1:0]    src;
            logic [FWD_DEPTH-1:0] hit;
            logic [SEL_W-1:0]     sel;

            assign src         = id_src[gi*REG_AW +: REG_AW];
            // Unused sources and r0 can never create a dependency.
            assign src_live[gi] = id_src_used[gi] && (src != '0);

            // hit[k] : the entry now in stage k will sit in stage k+1 when this
            // instruction reaches EX, so it is reachable with select k+1.
            for (gk = 0; gk < FWD_DEPTH; gk++) begin : g_stage
                assign hit[gk] = src_live[gi] && shadow_reg[gk].valid && shadow_reg[gk].wr &&
                                 (shadow_reg[gk].dst == STAGE_AW'(src));
            end

            // Nearest producer wins: scan from oldest to youngest, younger overrides.
            always_comb begin
                sel = SEL_W'(FWD_NONE);
                for (int k = FWD_DEPTH; k >= 1; k--) begin
                    if (hit[k-1]) begin
                        sel = SEL_W'(k);
                    end
                end
            end

            // A load in EX has no data until end of MEM, so a consumer must wait a cycle.
            assign lu_hit[gi]     = src_live[gi] && shadow_reg[0].valid && shadow_reg[0].wr &&
                                    shadow_reg[0].is_load && (shadow_reg[0].dst == STAGE_AW'(src));
            assign sb_src_hit[gi] = src_live[gi] && q_busy[gi];
            assign sel_next[gi*SEL_W +: SEL_W] = issue ? sel : SEL_W'(FWD_NONE);
        end
    endgenerate

    // Scoreboard queries: every source, plus the destination for the WAW check.
    assign q_addr    = {id_dst, id_src};
    assign wr_hazard = id_wr && (id_dst != '0) && q_busy[NUM_SRC];
    assign sb_hazard = (|sb_src_hit) || wr_hazard;
    assign load_use  = |lu_hit;

    assign stall_int = id_valid && (load_use || sb_hazard) && !flush;
    assign issue     = id_valid && !stall_int && !flush;

    // Long ops without a destination have nothing to track.
    assign sb_set    = issue && long_op && id_wr && (id_dst != '0);

    // Build the entry entering EX; long ops travel as non-writers since their
    // result is never forwarded.
    always_comb begin
        s0_next = STAGE_BUBBLE;
        if (issue) begin
            s0_next.valid   = 1'b1;
            s0_next.wr      = id_wr && (id_dst != '0) && !long_op;
            s0_next.is_load = id_is_load;
            s0_next.dst     = STAGE_AW'(id_dst);
        end
    end

    // Shadow pipeline advances every cycle; stalls appear as bubbles in EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg <= '0;
        end else begin
            shadow_reg <= {shadow_reg[FWD_DEPTH-1:0], s0_next};
        end
    end

    // Operand selects travel into EX together with the instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_sel_reg <= '0;
        end else begin
            fwd_sel_reg <= sel_next;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (stall_int && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    lat_scoreboard #(
        .REG_AW (REG_AW),
        .LAT_W  (LAT_W),
        .NQ     (NQ)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (sb_set),
        .set_addr (id_dst),
        .set_val  (id_lat),
        .q_addr   (q_addr),
        .q_busy   (q_busy),
        .any_busy (lat_busy)
    );

    assign stall        = stall_int;
    assign fwd_sel      = fwd_sel_reg;
    assign ex_valid     = shadow_reg[0].valid;
    assign stall_cycles = stall_cnt_reg;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: expected EX-side results are queued when
// each instruction is driven and compared after the clock edge.
module tb_fwd_hazard_ctrl;

    localparam int REG_AW    = 4;
    localparam int NUM_SRC   = 2;
    localparam int FWD_DEPTH = 2;
    localparam int LAT_W     = 3;
    localparam int CNT_W     = 4;
    localparam int SAT       = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [7:0]  id_src = '0;
    logic [1:0]  id_src_used = '0;
    logic        id_wr = 1'b0;
    logic [3:0]  id_dst = '0;
    logic        id_is_load = 1'b0;
    logic [2:0]  id_lat = '0;
    logic        stall;
    logic [3:0]  fwd_sel;
    logic        ex_valid;
    logic        lat_busy;
    logic [3:0]  stall_cycles;

    typedef struct {
        logic       exv;
        logic [1:0] s0;
        logic [1:0] s1;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   sc_model = 0;

    fwd_hazard_ctrl #(
        .REG_AW    (REG_AW),
        .NUM_SRC   (NUM_SRC),
        .FWD_DEPTH (FWD_DEPTH),
        .LAT_W     (LAT_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_src       (id_src),
        .id_src_used  (id_src_used),
        .id_wr        (id_wr),
        .id_dst       (id_dst),
        .id_is_load   (id_is_load),
        .id_lat       (id_lat),
        .stall        (stall),
        .fwd_sel      (fwd_sel),
        .ex_valid     (ex_valid),
        .lat_busy     (lat_busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One ID cycle: drive an instruction, check the combinational stall/busy,
    // queue the EX-side expectation, clock, then pop and compare.
    task automatic cyc(input string tag, input logic v, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [1:0] used, input logic wr, input logic [3:0] dst, input logic ld,
                       input logic [2:0] lat, input logic fl, input logic e_stall, input logic e_busy,
                       input logic [1:0] e_s0, input logic [1:0] e_s1);
        exp_t e;
        id_valid    = v;
        id_src      = {s1, s0};
        id_src_used = used;
        id_wr       = wr;
        id_dst      = dst;
        id_is_load  = ld;
        id_lat      = lat;
        flush       = fl;
        #2;
        check($sformatf("%s/stall", tag), 32'(stall), 32'(e_stall));
        check($sformatf("%s/lat_busy", tag), 32'(lat_busy), 32'(e_busy));
        e.exv = v && !e_stall && !fl;
        e.s0  = e.exv ? e_s0 : 2'd0;
        e.s1  = e.exv ? e_s1 : 2'd0;
        e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (e_stall && sc_model < SAT) sc_model++;
        e = exp_q.pop_front();
        check($sformatf("%s/ex_valid", e.tag), 32'(ex_valid), 32'(e.exv));
        check($sformatf("%s/fwd_sel0", e.tag), 32'(fwd_sel[1:0]), 32'(e.s0));
        check($sformatf("%s/fwd_sel1", e.tag), 32'(fwd_sel[3:2]), 32'(e.s1));
        check($sformatf("%s/stall_cycles", e.tag), 32'(stall_cycles), 32'(sc_model));
        $display("txn %-16s v=%0b src=%0d,%0d dst=%0d stall=%0b ex_valid=%0b fwd_sel=%0d,%0d stall_cycles=%0d",
                 tag, v, s0, s1, dst, e_stall, ex_valid, fwd_sel[1:0], fwd_sel[3:2], stall_cycles);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc("idle", 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        check("rst/stall", 32'(stall), 0);
        check("rst/ex_valid", 32'(ex_valid), 0);
        check("rst/fwd_sel", 32'(fwd_sel), 0);
        check("rst/lat_busy", 32'(lat_busy), 0);
        check("rst/stall_cycles", 32'(stall_cycles), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back producer/consumer -> select 1.
        cyc("a_add_r3",     1, 1, 2, 2'b11, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        cyc("a_use_r3",     1, 3, 2, 2'b11, 1, 8, 0, 0, 0, 0, 0, 1, 0);
        idle(3);
        // One gap -> select 2 (on src1).
        cyc("b_add_r3",     1, 1, 2, 2'b11, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        cyc("b_use_gap1",   1, 1, 3, 2'b11, 1, 8, 0, 0, 0, 0, 0, 0, 2);
        idle(3);
        // Two gaps -> register file.
        cyc("c_add_r3",     1, 1, 2, 2'b11, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        cyc("c_use_gap2",   1, 3, 3, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Load-use: one stall cycle, then forward from MEM/WB.
        cyc("d_load_r5",    1, 1, 0, 2'b01, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        cyc("d_use_stall",  1, 5, 2, 2'b11, 1, 9, 0, 0, 0, 1, 0, 0, 0);
        cyc("d_use_issue",  1, 5, 2, 2'b11, 1, 9, 0, 0, 0, 0, 0, 2, 0);
        check("d_stall_cycles_one", 32'(stall_cycles), 1);
        idle(3);

        // Nearest producer wins; unused source and r0 never forward or stall.
        cyc("e_add_r3_old", 1, 1, 2, 2'b11, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        cyc("e_add_r3_new", 1, 1, 2, 2'b11, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        cyc("e_near",       1, 3, 0, 2'b11, 1, 8, 0, 0, 0, 0, 0, 1, 0);
        cyc("e_unused_src", 1, 3, 3, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        cyc("e_load_r0",    1, 1, 2, 2'b11, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc("e_use_r0",     1, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Long op latency 4: reader stalls 4 cycles, then reads the regfile.
        cyc("f_mac_r7",     1, 1, 2, 2'b11, 1, 7, 0, 4, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc("f_wait",   1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        end
        cyc("f_issue",      1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("f_stall_cycles_five", 32'(stall_cycles), 5);
        idle(2);

        // WAW on a pending long-op destination.
        cyc("g_mac_r9",     1, 1, 2, 2'b11, 1, 9, 0, 2, 0, 0, 0, 0, 0);
        cyc("g_waw",        1, 1, 2, 2'b11, 1, 9, 0, 0, 0, 1, 1, 0, 0);
        cyc("g_waw",        1, 1, 2, 2'b11, 1, 9, 0, 0, 0, 1, 1, 0, 0);
        cyc("g_waw_issue",  1, 1, 2, 2'b11, 1, 9, 0, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Flush: squashed producers neither forward nor arm the scoreboard.
        cyc("h_add_flush",  1, 1, 2, 2'b11, 1, 3, 0, 0, 1, 0, 0, 0, 0);
        cyc("h_use_r3",     1, 3, 1, 2'b11, 1, 8, 0, 0, 0, 0, 0, 0, 0);
        cyc("h_mac_flush",  1, 1, 2, 2'b11, 1, 7, 0, 5, 1, 0, 0, 0, 0);
        cyc("h_use_r7",     1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("h_load_r5",    1, 1, 0, 2'b01, 1, 5, 1, 0, 0, 0, 0, 0, 0);
        cyc("h_use_flush",  1, 5, 0, 2'b01, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc("h_use_after",  1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2, 0);
        idle(3);

        // Reset during a countdown with a pending stall.
        cyc("i_add_r3",     1, 1, 2, 2'b11, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        cyc("i_mac_r7",     1, 3, 2, 2'b11, 1, 7, 0, 7, 0, 0, 0, 1, 0);
        id_valid = 1; id_src = 8'h07; id_src_used = 2'b01; id_wr = 0;
        id_dst = 0; id_is_load = 0; id_lat = 0; flush = 0;
        #2;
        check("i_pre/stall", 32'(stall), 1);
        check("i_pre/lat_busy", 32'(lat_busy), 1);
        rst_n = 1'b0;
        #1;
        check("i_rst/stall", 32'(stall), 0);
        check("i_rst/lat_busy", 32'(lat_busy), 0);
        check("i_rst/fwd_sel", 32'(fwd_sel), 0);
        check("i_rst/ex_valid", 32'(ex_valid), 0);
        check("i_rst/stall_cycles", 32'(stall_cycles), 0);
        $display("txn %-16s stall=%0b lat_busy=%0b fwd_sel=%0h ex_valid=%0b stall_cycles=%0d",
                 "i_async_reset", stall, lat_busy, fwd_sel, ex_valid, stall_cycles);
        sc_model = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc("i_after_reset", 1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 21 stall cycles into a 4-bit counter -> saturates at 15.
        for (int r = 0; r < 3; r++) begin
            cyc("j_mac_r7",  1, 1, 2, 2'b11, 1, 7, 0, 7, 0, 0, 0, 0, 0);
            for (int i = 0; i < 7; i++) begin
                cyc("j_wait", 1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 1, 1, 0, 0);
            end
            cyc("j_issue",   1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        check("j_saturated", 32'(stall_cycles), 32'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
